// File: rtl/tucanos_dispatcher.sv
// -----------------------------------------------------------------------------
// tucanos_dispatcher
//
// OS-side counterpart of the process watchdog. A watchdog event (quantum
// expiry, WAIT or HALT) saves the PC of the interrupted user process and sends
// the CPU into the OS. An OS RESUME instruction picks the next READY process in
// round-robin order and sends the CPU to that process's saved PC. The block
// tracks the status of the three user processes.
//
// Ports
//   clock            in   system clock, rising edge
//   reset_n          in   synchronous reset, active low
//   jump_enabler     in   watchdog jump request (level; acts on its rising edge)
//   state_register   in   watchdog cause: 1..3 quantum expiry, 4 WAIT, 5 HALT
//   program_counter  in   current fetch PC
//   opcode           in   current instruction opcode
//   io_done          in   1-cycle pulse: I/O finished for process io_pid
//   io_pid           in   process index (1..3) qualified by io_done
//   os_jump          out  1-cycle pulse: branch to jump_address (OS entry)
//   resume_jump      out  1-cycle pulse: branch to jump_address (resume)
//   jump_address     out  branch target, valid while a jump pulse is high
//   current_process  out  running / last dispatched process, 0 = none yet
//   process_status   out  2 bits per process, [1:0] = p1
//                         (00 READY, 01 WAITING, 10 HALTED)
//   all_halted       out  sticky: every process has halted
//   dbg_state        out  FSM state (0 OS, 1 RUN, 2 DONE)
//
// Pulse semantics: os_jump and resume_jump are never high together. Each is
// high for exactly one cycle, and jump_address is meaningful only in that
// cycle. There is no back-pressure. The consumer must take the branch in the
// cycle in which the pulse is seen.
// -----------------------------------------------------------------------------
module tucanos_dispatcher #(
  parameter int unsigned        PC_WIDTH      = 12,
  parameter logic [PC_WIDTH-1:0] OS_BASE      = 12'd256,
  parameter logic [PC_WIDTH-1:0] P1_BASE      = 12'd512,
  parameter logic [PC_WIDTH-1:0] P2_BASE      = 12'd1024,
  parameter logic [PC_WIDTH-1:0] P3_BASE      = 12'd1536,
  parameter logic [5:0]          RESUME_OPCODE = 6'b011111
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                jump_enabler,
  input  logic [31:0]         state_register,
  input  logic [PC_WIDTH-1:0] program_counter,
  input  logic [5:0]          opcode,
  input  logic                io_done,
  input  logic [1:0]          io_pid,
  output logic                os_jump,
  output logic                resume_jump,
  output logic [PC_WIDTH-1:0] jump_address,
  output logic [1:0]          current_process,
  output logic [5:0]          process_status,
  output logic                all_halted,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_OS   = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ST_READY   = 2'b00;
  localparam logic [1:0] ST_WAITING = 2'b01;
  localparam logic [1:0] ST_HALTED  = 2'b10;

  state_t              state_q, state_d;
  logic                jump_en_q, jump_en_d;
  logic                os_jump_q, os_jump_d;
  logic                resume_jump_q, resume_jump_d;
  logic [PC_WIDTH-1:0] jump_address_q, jump_address_d;
  logic [1:0]          current_process_q, current_process_d;
  logic                all_halted_q, all_halted_d;

  // Entry 0 is an unused slot. It keeps io_pid=0 and current_process=0
  // lookups in range. It is never written after reset.
  logic [PC_WIDTH-1:0] saved_pc_q [0:3];
  logic [PC_WIDTH-1:0] saved_pc_d [0:3];
  logic [1:0]          status_q   [0:3];
  logic [1:0]          status_d   [0:3];

  logic                jump_rise;
  logic                resume_req;
  logic                every_halted;
  logic                found;
  logic [1:0]          pick;
  logic [2:0]          cand;

  assign jump_rise    = jump_enabler & ~jump_en_q;
  assign resume_req   = (opcode == RESUME_OPCODE) && (program_counter >= OS_BASE);
  assign every_halted = (status_q[1] == ST_HALTED) && (status_q[2] == ST_HALTED) &&
                        (status_q[3] == ST_HALTED);

  always_comb begin
    state_d           = state_q;
    jump_en_d         = jump_enabler;
    os_jump_d         = 1'b0;
    resume_jump_d     = 1'b0;
    jump_address_d    = jump_address_q;
    current_process_d = current_process_q;
    all_halted_d      = all_halted_q;
    saved_pc_d        = saved_pc_q;
    status_d          = status_q;
    found             = 1'b0;
    pick              = 2'd0;
    cand              = 3'd0;

    // I/O completion is applied first. A WAIT event in the same cycle for
    // the same process overrides it further down.
    if (io_done && (status_q[io_pid] == ST_WAITING)) begin
      status_d[io_pid] = ST_READY;
    end

    case (state_q)
      S_RUN: begin
        if (jump_rise) begin
          // WAIT and HALT retire the trapping instruction, so the process
          // resumes after it. A quantum expiry re-executes the current PC.
          case (state_register)
            32'd4: begin
              saved_pc_d[current_process_q] = program_counter + PC_WIDTH'(1);
              status_d[current_process_q]   = ST_WAITING;
            end
            32'd5: begin
              saved_pc_d[current_process_q] = program_counter + PC_WIDTH'(1);
              status_d[current_process_q]   = ST_HALTED;
            end
            default: begin
              saved_pc_d[current_process_q] = program_counter;
            end
          endcase
          os_jump_d      = 1'b1;
          jump_address_d = OS_BASE;
          state_d        = S_OS;
        end
      end

      S_OS: begin
        if (resume_req) begin
          // Round-robin scan: current+1, current+2, current+3, wrapping 3->1.
          // The scan uses registered status. A same-cycle io_done does not
          // affect this scan.
          for (int k = 1; k < 4; k++) begin
            cand = {1'b0, current_process_q} + 3'(k);
            if (cand > 3'd3) cand = cand - 3'd3;
            if (!found && (status_q[cand[1:0]] == ST_READY)) begin
              found = 1'b1;
              pick  = cand[1:0];
            end
          end
          if (found) begin
            resume_jump_d     = 1'b1;
            jump_address_d    = saved_pc_q[pick];
            current_process_d = pick;
            state_d           = S_RUN;
          end else if (every_halted) begin
            all_halted_d = 1'b1;
            state_d      = S_DONE;
          end
          // Otherwise some process is still waiting on I/O. Stay in OS and
          // let the OS reissue RESUME.
        end
      end

      S_DONE: begin
      end

      default: state_d = S_OS;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= S_OS;
      jump_en_q         <= 1'b0;
      os_jump_q         <= 1'b0;
      resume_jump_q     <= 1'b0;
      jump_address_q    <= '0;
      current_process_q <= 2'd0;
      all_halted_q      <= 1'b0;
      saved_pc_q[0]     <= '0;
      saved_pc_q[1]     <= P1_BASE;
      saved_pc_q[2]     <= P2_BASE;
      saved_pc_q[3]     <= P3_BASE;
      for (int i = 0; i < 4; i++) status_q[i] <= ST_READY;
    end else begin
      state_q           <= state_d;
      jump_en_q         <= jump_en_d;
      os_jump_q         <= os_jump_d;
      resume_jump_q     <= resume_jump_d;
      jump_address_q    <= jump_address_d;
      current_process_q <= current_process_d;
      all_halted_q      <= all_halted_d;
      for (int i = 0; i < 4; i++) begin
        saved_pc_q[i] <= saved_pc_d[i];
        status_q[i]   <= status_d[i];
      end
    end
  end

  assign os_jump         = os_jump_q;
  assign resume_jump     = resume_jump_q;
  assign jump_address    = jump_address_q;
  assign current_process = current_process_q;
  assign process_status  = {status_q[3], status_q[2], status_q[1]};
  assign all_halted      = all_halted_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_tucanos_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_tucanos_dispatcher
//
// Bench for tucanos_dispatcher. It runs directed scenarios first and then a
// randomized phase. A behavioural model of the OS/process bookkeeping predicts
// the outputs after every clock edge.
// -----------------------------------------------------------------------------
module tb_tucanos_dispatcher;

  localparam logic [5:0] RESUME = 6'b011111;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset_n;
  logic        jump_enabler;
  logic [31:0] state_register;
  logic [11:0] program_counter;
  logic [5:0]  opcode;
  logic        io_done;
  logic [1:0]  io_pid;
  logic        os_jump;
  logic        resume_jump;
  logic [11:0] jump_address;
  logic [1:0]  current_process;
  logic [5:0]  process_status;
  logic        all_halted;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  tucanos_dispatcher dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .jump_enabler    (jump_enabler),
    .state_register  (state_register),
    .program_counter (program_counter),
    .opcode          (opcode),
    .io_done         (io_done),
    .io_pid          (io_pid),
    .os_jump         (os_jump),
    .resume_jump     (resume_jump),
    .jump_address    (jump_address),
    .current_process (current_process),
    .process_status  (process_status),
    .all_halted      (all_halted),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Status codes: 0 READY, 1 WAITING, 2 HALTED. Index 0 of m_st is unused.
  logic [11:0] m_pc [1:3];
  logic [1:0]  m_st [0:3];
  logic        m_run, m_done, m_jd, m_ah;
  logic [1:0]  m_cp;
  logic        exp_os, exp_res;
  logic [11:0] exp_addr;

  task automatic model_step();
    logic [1:0] nst [0:3];
    int         order [3];
    bit         hit;
    exp_os  = 1'b0;
    exp_res = 1'b0;
    if (!reset_n) begin
      m_pc[1] = 12'd512; m_pc[2] = 12'd1024; m_pc[3] = 12'd1536;
      for (int i = 0; i < 4; i++) m_st[i] = 2'd0;
      m_run = 0; m_done = 0; m_jd = 0; m_ah = 0; m_cp = 2'd0;
      return;
    end
    nst = m_st;
    if (io_done && io_pid != 2'd0 && m_st[io_pid] == 2'd1) nst[io_pid] = 2'd0;
    if (m_run) begin
      if (jump_enabler && !m_jd) begin
        if (state_register == 32'd4) begin
          m_pc[m_cp] = program_counter + 12'd1; nst[m_cp] = 2'd1;
        end else if (state_register == 32'd5) begin
          m_pc[m_cp] = program_counter + 12'd1; nst[m_cp] = 2'd2;
        end else begin
          m_pc[m_cp] = program_counter;
        end
        exp_os = 1'b1; exp_addr = 12'd256; m_run = 0;
      end
    end else if (!m_done && opcode == RESUME && program_counter >= 12'd256) begin
      for (int i = 0; i < 3; i++) order[i] = (int'(m_cp) + i) % 3 + 1;
      hit = 0;
      for (int i = 0; i < 3; i++) begin
        if (!hit && m_st[order[i]] == 2'd0) begin
          hit = 1; exp_res = 1'b1; m_cp = 2'(order[i]);
          exp_addr = m_pc[order[i]]; m_run = 1;
        end
      end
      if (!hit && m_st[1] == 2'd2 && m_st[2] == 2'd2 && m_st[3] == 2'd2) begin
        m_done = 1; m_ah = 1;
      end
    end
    m_st = nst;
    m_jd = jump_enabler;
  endtask

  task automatic check_outputs();
    check("os_jump", os_jump, exp_os);
    check("resume_jump", resume_jump, exp_res);
    check("current_process", current_process, m_cp);
    check("process_status", process_status, {m_st[3], m_st[2], m_st[1]});
    check("all_halted", all_halted, m_ah);
    if (exp_os || exp_res) check("jump_address", jump_address, exp_addr);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    jump_enabler = 0; opcode = 6'd0; program_counter = 12'd0;
    io_done = 0; io_pid = 2'd0; state_register = 32'd0;
  endtask

  // Watchdog event while a process runs; expects the OS-entry pulse.
  task automatic event_at(input logic [11:0] pc, input logic [31:0] code);
    jump_enabler = 1; state_register = code; program_counter = pc;
    cycle();
    check("ev_os_jump", os_jump, 1);
    check("ev_addr", jump_address, 12'd256);
    jump_enabler = 0;
  endtask

  task automatic resume_req();
    opcode = RESUME; program_counter = 12'd300;
    cycle();
    opcode = 6'd0; program_counter = 12'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 0;
    idle();
    cycle();
    check("rst_os_jump", os_jump, 0);
    check("rst_resume_jump", resume_jump, 0);
    check("rst_cp", current_process, 0);
    check("rst_status", process_status, 0);
    check("rst_all_halted", all_halted, 0);
    reset_n = 1;
    cycle();

    // 1: first dispatch goes to p1 at its base.
    resume_req();
    check("t1_resume", resume_jump, 1);
    check("t1_addr", jump_address, 12'd512);
    check("t1_cp", current_process, 1);

    // 2: quantum expiry on p1, then p2.
    event_at(12'd517, 32'd1);
    resume_req();
    check("t2_addr", jump_address, 12'd1024);
    check("t2_cp", current_process, 2);

    // 3: p2 waits, p3 runs, and the next RESUME skips p2.
    event_at(12'd1030, 32'd4);
    check("t3_status_p2", process_status[3:2], 2'b01);
    resume_req();
    check("t3_addr_p3", jump_address, 12'd1536);
    event_at(12'd1540, 32'd2);
    resume_req();
    check("t3_addr_p1", jump_address, 12'd517);
    check("t3_cp", current_process, 1);

    // 4: p1 and p3 halted, p2 waiting, so there is no dispatch until io_done.
    event_at(12'd520, 32'd5);
    resume_req();
    check("t4_addr_p3", jump_address, 12'd1540);
    event_at(12'd1600, 32'd5);
    resume_req();
    check("t4_no_resume", resume_jump, 0);
    check("t4_no_os", os_jump, 0);
    io_done = 1; io_pid = 2'd2;
    cycle();
    io_done = 0; io_pid = 2'd0;
    resume_req();
    check("t4_resume", resume_jump, 1);
    check("t4_addr", jump_address, 12'd1031);
    check("t4_cp", current_process, 2);
    check("t4_status", process_status, 6'b100010);

    // 5: all processes halted, so the block goes to the absorbing state.
    event_at(12'd1100, 32'd5);
    resume_req();
    check("t5_all_halted", all_halted, 1);
    check("t5_status", process_status, 6'b101010);
    check("t5_no_resume", resume_jump, 0);
    resume_req();
    check("t5_no_resume2", resume_jump, 0);
    jump_enabler = 1; cycle(); jump_enabler = 0; cycle();

    // 6: reset during RUN with jump_enabler held high.
    reset_n = 0; cycle(); reset_n = 1;
    resume_req();
    check("t6_pre_cp", current_process, 1);
    jump_enabler = 1; state_register = 32'd1; reset_n = 0;
    cycle();
    check("t6_rst_cp", current_process, 0);
    check("t6_rst_status", process_status, 0);
    check("t6_rst_halted", all_halted, 0);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_no_os_held", os_jump, 0);
    end
    opcode = RESUME; program_counter = 12'd300;
    cycle();
    opcode = 6'd0;
    check("t6_resume_base", jump_address, 12'd512);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_no_os_run", os_jump, 0);
    end
    jump_enabler = 0; cycle();
    jump_enabler = 1; program_counter = 12'd600;
    cycle();
    check("t6_fresh_os", os_jump, 1);
    idle();

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      int r;
      reset_n = ($urandom_range(0, 299) != 0) && !(m_done && $urandom_range(0, 19) == 0);
      jump_enabler = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      if (r < 5)       state_register = 32'($urandom_range(1, 3));
      else if (r < 7)  state_register = 32'd4;
      else if (r < 8)  state_register = 32'd5;
      else             state_register = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      program_counter = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(0, 255))
                                                    : 12'($urandom);
      opcode = ($urandom_range(0, 9) < 3) ? RESUME : 6'($urandom);
      io_done = ($urandom_range(0, 3) == 0);
      io_pid = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
